// File: rtl/tick_scroller.sv
// Turns a synchronous divided-clock square wave into step events that walk a
// character index through a message, pausing on the last character before wrapping.
module tick_scroller #(
    parameter int MSG_LEN    = 16,
    parameter int HOLD_TICKS = 3
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic                       tick_in,
    input  logic                       run,
    input  logic                       restart,
    output logic [$clog2(MSG_LEN)-1:0] char_idx,
    output logic                       step,
    output logic                       wrap,
    output logic                       busy,
    output logic                       blink
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [AW-1:0] IDX_LAST  = AW'(MSG_LEN - 1);
    localparam logic [AW-1:0] IDX_ONE   = AW'(1);
    localparam logic [HW-1:0] HOLD_LAST = (HOLD_TICKS > 0) ? HW'(HOLD_TICKS - 1) : '0;
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   char_idx_reg, char_idx_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic            step_reg, step_next;
    logic            wrap_reg, wrap_next;
    logic            blink_reg;
    logic            tick_d_reg;
    logic            tick_rise;

    assign tick_rise = tick_in & ~tick_d_reg;

    // tick_d resets high so a tick already high at reset release is not an edge.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            char_idx_reg <= '0;
            hold_cnt_reg <= '0;
            step_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
            blink_reg    <= 1'b0;
            tick_d_reg   <= 1'b1;
        end else begin
            state_reg    <= state_next;
            char_idx_reg <= char_idx_next;
            hold_cnt_reg <= hold_cnt_next;
            step_reg     <= step_next;
            wrap_reg     <= wrap_next;
            blink_reg    <= blink_reg ^ tick_rise;
            tick_d_reg   <= tick_in;
        end
    end

    always_comb begin
        state_next    = state_reg;
        char_idx_next = char_idx_reg;
        hold_cnt_next = hold_cnt_reg;
        step_next     = 1'b0;
        wrap_next     = 1'b0;
        if (restart) begin
            char_idx_next = '0;
            hold_cnt_next = '0;
            state_next    = run ? RUN : IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (run) state_next = RUN;
                end
                RUN: begin
                    if (!run) begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end else if (tick_rise) begin
                        if (char_idx_reg < IDX_LAST) begin
                            char_idx_next = char_idx_reg + IDX_ONE;
                            step_next     = 1'b1;
                        end else if (HOLD_TICKS == 0) begin
                            char_idx_next = '0;
                            step_next     = 1'b1;
                            wrap_next     = 1'b1;
                        end else begin
                            state_next    = HOLD;
                            hold_cnt_next = '0;
                        end
                    end
                end
                HOLD: begin
                    if (!run) begin
                        state_next    = IDLE;
                        hold_cnt_next = '0;
                    end else if (tick_rise) begin
                        if (hold_cnt_reg < HOLD_LAST) begin
                            hold_cnt_next = hold_cnt_reg + HOLD_ONE;
                        end else begin
                            char_idx_next = '0;
                            hold_cnt_next = '0;
                            step_next     = 1'b1;
                            wrap_next     = 1'b1;
                            state_next    = RUN;
                        end
                    end
                end
                default: begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state_reg != IDLE);
        char_idx = char_idx_reg;
        step     = step_reg;
        wrap     = wrap_reg;
        blink    = blink_reg;
    end

endmodule

// File: tb/tb_tick_scroller.sv
// Drives two scroller instances (4 chars/2 hold and 5 chars/no hold) from shared
// stimulus; a reference model queues expected outputs each cycle.
module tb_tick_scroller;

    logic       clk_in;
    logic       rst_n;
    logic       tick_in;
    logic       run;
    logic       restart;
    logic [1:0] idx_a;
    logic       step_a, wrap_a, busy_a, blink_a;
    logic [2:0] idx_b;
    logic       step_b, wrap_b, busy_b, blink_b;

    tick_scroller #(.MSG_LEN(4), .HOLD_TICKS(2)) dut_a (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .run(run), .restart(restart),
        .char_idx(idx_a), .step(step_a), .wrap(wrap_a), .busy(busy_a), .blink(blink_a)
    );

    tick_scroller #(.MSG_LEN(5), .HOLD_TICKS(0)) dut_b (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .run(run), .restart(restart),
        .char_idx(idx_b), .step(step_b), .wrap(wrap_b), .busy(busy_b), .blink(blink_b)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int st;    // 0 idle, 1 run, 2 hold
        int idx;
        int hold;
        bit step;
        bit wrap;
        bit blink;
        bit td;
    } mdl_t;

    mdl_t m [2];
    mdl_t q_a [$];
    mdl_t q_b [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   wrap_cnt_a, wrap_cnt_b, max_idx_b;
    bit   bl;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_rst();
        mdl_t r;
        r.st = 0; r.idx = 0; r.hold = 0;
        r.step = 0; r.wrap = 0; r.blink = 0; r.td = 1;
        return r;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t c, input int len, input int ht,
                                      input bit tk, input bit rn, input bit rs);
        mdl_t n;
        bit   rise;
        rise   = tk && !c.td;
        n      = c;
        n.td   = tk;
        n.step = 0;
        n.wrap = 0;
        if (rise) n.blink = !c.blink;
        if (rs) begin
            n.idx = 0; n.hold = 0; n.st = rn ? 1 : 0;
        end else if (c.st == 0) begin
            if (rn) n.st = 1;
        end else if (!rn) begin
            n.st = 0; n.hold = 0;
        end else if (rise) begin
            if (c.st == 1) begin
                if (c.idx < len - 1) begin
                    n.idx = c.idx + 1; n.step = 1;
                end else if (ht == 0) begin
                    n.idx = 0; n.step = 1; n.wrap = 1;
                end else begin
                    n.st = 2; n.hold = 0;
                end
            end else begin
                if (c.hold < ht - 1) begin
                    n.hold = c.hold + 1;
                end else begin
                    n.idx = 0; n.hold = 0; n.step = 1; n.wrap = 1; n.st = 1;
                end
            end
        end
        return n;
    endfunction

    // One clock: drive at negedge, queue the model's prediction, compare after posedge.
    task automatic cycle(input bit tk, input bit rn, input bit rs);
        mdl_t e;
        @(negedge clk_in);
        tick_in = tk; run = rn; restart = rs;
        m[0] = rst_n ? mdl_next(m[0], 4, 2, tk, rn, rs) : mdl_rst();
        m[1] = rst_n ? mdl_next(m[1], 5, 0, tk, rn, rs) : mdl_rst();
        q_a.push_back(m[0]);
        q_b.push_back(m[1]);
        @(posedge clk_in);
        #1;
        e = q_a.pop_front();
        chk("a.idx",   int'(idx_a),   e.idx);
        chk("a.step",  int'(step_a),  int'(e.step));
        chk("a.wrap",  int'(wrap_a),  int'(e.wrap));
        chk("a.blink", int'(blink_a), int'(e.blink));
        chk("a.busy",  int'(busy_a),  (e.st != 0) ? 1 : 0);
        e = q_b.pop_front();
        chk("b.idx",   int'(idx_b),   e.idx);
        chk("b.step",  int'(step_b),  int'(e.step));
        chk("b.wrap",  int'(wrap_b),  int'(e.wrap));
        chk("b.blink", int'(blink_b), int'(e.blink));
        chk("b.busy",  int'(busy_b),  (e.st != 0) ? 1 : 0);
        wrap_cnt_a += int'(wrap_a);
        wrap_cnt_b += int'(wrap_b);
        if (int'(idx_b) > max_idx_b) max_idx_b = int'(idx_b);
    endtask

    // Rising cycle of an 8-cycle tick period (4 high, 4 low).
    task automatic rise(input bit rn, input bit rs);
        cycle(1'b1, rn, rs);
    endtask

    task automatic rest(input bit rn);
        for (int i = 0; i < 3; i++) cycle(1'b1, rn, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, rn, 1'b0);
    endtask

    task automatic do_tick();
        rise(1'b1, 1'b0);
        rest(1'b1);
    endtask

    initial begin
        rst_n = 1'b0; tick_in = 1'b1; run = 1'b1; restart = 1'b0;
        m[0] = mdl_rst(); m[1] = mdl_rst();
        wrap_cnt_a = 0; wrap_cnt_b = 0; max_idx_b = 0;
        repeat (3) @(posedge clk_in);

        // Reset release with tick already high: no phantom edge
        @(negedge clk_in);
        rst_n = 1'b1;
        #1;
        chk("rst.idx", int'(idx_a), 0);
        chk("rst.blink", int'(blink_a), 0);
        chk("rst.busy", int'(busy_a), 0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("phantom.idx", int'(idx_a), 0);
        chk("phantom.blink", int'(blink_a), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_tick();
        chk("scroll.idx3", int'(idx_a), 3);

        // Full message cycles from index 0
        cycle(1'b0, 1'b1, 1'b1);
        wrap_cnt_a = 0; wrap_cnt_b = 0; max_idx_b = 0;
        for (int i = 0; i < 12; i++) do_tick();
        chk("wraps.a", wrap_cnt_a, 2);
        chk("wraps.b", wrap_cnt_b, 2);
        chk("max_idx.b", max_idx_b, 4);

        // Pause on a tick rise at index 2, then resume
        do_tick();
        do_tick();
        chk("pause.pre_idx", int'(idx_a), 2);
        bl = m[0].blink;
        rise(1'b0, 1'b0);
        chk("pause.idx", int'(idx_a), 2);
        chk("pause.busy", int'(busy_a), 0);
        chk("pause.blink", int'(blink_a), int'(!bl));
        rest(1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        do_tick();
        chk("resume.idx", int'(idx_a), 3);

        // Restart coincident with a tick rise while holding on index 3
        cycle(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) do_tick();
        chk("hold.idx", int'(idx_a), 3);
        bl = m[0].blink;
        rise(1'b1, 1'b1);
        chk("restart.idx", int'(idx_a), 0);
        chk("restart.step", int'(step_a), 0);
        chk("restart.wrap", int'(wrap_a), 0);
        chk("restart.busy", int'(busy_a), 1);
        chk("restart.blink", int'(blink_a), int'(!bl));
        rest(1'b1);
        do_tick();
        chk("after_restart.idx", int'(idx_a), 1);

        // Asynchronous reset between clock edges while in HOLD
        for (int i = 0; i < 3; i++) do_tick();
        chk("hold2.idx", int'(idx_a), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.idx", int'(idx_a), 0);
        chk("areset.step", int'(step_a), 0);
        chk("areset.wrap", int'(wrap_a), 0);
        chk("areset.blink", int'(blink_a), 0);
        chk("areset.busy", int'(busy_a), 0);
        chk("areset.idx_b", int'(idx_b), 0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
